fsm_state_tracker: RTL and testbench



---
 rtl/fsm_state_tracker_if.sv | 34 +++
 rtl/fsm_state_tracker.sv | 102 ++++++++++
 tb/tb_fsm_state_tracker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fsm_state_tracker_if.sv
// Transition-log channel of fsm_state_tracker: head record, valid/ready handshake,
// occupancy and sticky overflow flag.
interface fsm_state_tracker_if #(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEPTH   = 8
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;
    logic [CNT_W-1:0]   out_dwell;
    logic [OCC_W-1:0]   count;
    logic               overflow;

    modport master (
        output out_valid,
        output out_state,
        output out_dwell,
        output count,
        output overflow,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_state,
        input  out_dwell,
        input  count,
        input  overflow,
        output out_ready
    );
endinterface

// File: rtl/fsm_state_tracker.sv
// Samples an FSM state bus, measures per-state dwell and logs {state, dwell} per change
// into a FWFT FIFO. Define STATE_TRACKER_SAT_EN to saturate the dwell counter instead of wrapping.
module fsm_state_tracker #(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STATE_W-1:0]  state_in,
    fsm_state_tracker_if.master rec
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic               primed;
    logic [STATE_W-1:0] prev_state;
    logic [CNT_W-1:0]   dwell;

    logic [STATE_W-1:0] mem_state [DEPTH];
    logic [CNT_W-1:0]   mem_dwell [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               overflow;

    logic               change_c;
    logic               pop_c;
    logic               full_c;
    logic               accept_c;
    logic               drop_c;
    logic [CNT_W-1:0]   dwell_inc_c;
    logic [OCC_W-1:0]   occ_next_c;

    // Push/pop decisions; a full FIFO still accepts a push when the head leaves the same edge.
    always_comb begin
        change_c = primed && (state_in != prev_state);
        pop_c    = (occ != '0) && rec.out_ready;
        full_c   = (occ == OCC_FULL);
        accept_c = change_c && (!full_c || pop_c);
        drop_c   = change_c && full_c && !pop_c;
`ifdef STATE_TRACKER_SAT_EN
        dwell_inc_c = (dwell == '1) ? dwell : dwell + CNT_W'(1);
`else
        dwell_inc_c = dwell + CNT_W'(1);
`endif
        occ_next_c = occ;
        if (accept_c && !pop_c) begin
            occ_next_c = occ + OCC_W'(1);
        end else if (pop_c && !accept_c) begin
            occ_next_c = occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            primed     <= 1'b0;
            prev_state <= '0;
            dwell      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_state[PTR_W'(i)] <= '0;
                mem_dwell[PTR_W'(i)] <= '0;
            end
        end else begin
            // Sampling never stalls on backpressure.
            if (!primed) begin
                primed     <= 1'b1;
                prev_state <= state_in;
                dwell      <= CNT_W'(1);
            end else if (change_c) begin
                prev_state <= state_in;
                dwell      <= CNT_W'(1);
            end else begin
                dwell      <= dwell_inc_c;
            end

            if (accept_c) begin
                mem_state[wr_ptr] <= prev_state;
                mem_dwell[wr_ptr] <= dwell;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ_next_c;
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    assign rec.out_valid = (occ != '0);
    assign rec.count     = occ;
    assign rec.overflow  = overflow;
    assign rec.out_state = mem_state[rd_ptr];
    assign rec.out_dwell = mem_dwell[rd_ptr];
endmodule

// File: tb/tb_fsm_state_tracker.sv
// Bench for fsm_state_tracker: queue-based reference model checked every cycle,
// plus hand-computed expectations on the drained records.
module tb_fsm_state_tracker;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DEPTH   = 8;
    localparam int          DW_MAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [STATE_W-1:0] state_in = 4'd9;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    fsm_state_tracker_if #(.STATE_W(STATE_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

    fsm_state_tracker #(.STATE_W(STATE_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .state_in (state_in),
        .rec      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: unbounded run length, folded into the dwell field only when logged.
    bit m_primed = 1'b0;
    int m_prev   = 0;
    int m_run    = 0;
    bit m_ovf    = 1'b0;
    int mq_st[$];
    int mq_dw[$];

    // Records actually handed over by the DUT, in order.
    int pop_st[$];
    int pop_dw[$];

    function automatic int fold(input int n);
`ifdef STATE_TRACKER_SAT_EN
        return (n > DW_MAX) ? DW_MAX : n;
`else
        return n % (DW_MAX + 1);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_primed = 1'b0;
            m_prev   = 0;
            m_run    = 0;
            m_ovf    = 1'b0;
            mq_st.delete();
            mq_dw.delete();
        end else begin
            bit do_pop;
            do_pop = (mq_st.size() != 0) && bus.out_ready;
            if (do_pop) begin
                void'(mq_st.pop_front());
                void'(mq_dw.pop_front());
            end
            if (!m_primed) begin
                m_primed = 1'b1;
                m_prev   = int'(state_in);
                m_run    = 1;
            end else if (int'(state_in) != m_prev) begin
                if (mq_st.size() < DEPTH) begin
                    mq_st.push_back(m_prev);
                    mq_dw.push_back(fold(m_run));
                end else begin
                    m_ovf = 1'b1;
                end
                m_prev = int'(state_in);
                m_run  = 1;
            end else begin
                m_run++;
            end
        end
    end

    // Per-cycle comparison against the model, and capture of records about to be popped.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(mq_st.size() != 0));
            chk("count", 32'(bus.count), 32'(mq_st.size()));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (mq_st.size() != 0) begin
                chk("out_state", 32'(bus.out_state), 32'(mq_st[0]));
                chk("out_dwell", 32'(bus.out_dwell), 32'(mq_dw[0]));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && reset === 1'b0) begin
                pop_st.push_back(int'(bus.out_state));
                pop_dw.push_back(int'(bus.out_dwell));
            end
        end
    end

    task automatic cyc(input int st, input logic rdy, input logic rst);
        state_in      = STATE_W'(st);
        bus.out_ready = rdy;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pop(input string name, input int idx, input int st, input int dw);
        if (idx < pop_st.size()) begin
            chk({name, "_state"}, 32'(pop_st[idx]), 32'(st));
            chk({name, "_dwell"}, 32'(pop_dw[idx]), 32'(dw));
        end else begin
            chk({name, "_present"}, 32'(pop_st.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_idle_after_reset();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_out_state", 32'(bus.out_state), 32'd0);
        chk("rst_out_dwell", 32'(bus.out_dwell), 32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        cyc(9, 1'b0, 1'b1);
        cyc(9, 1'b1, 1'b1);
        chk_en = 1'b1;
        chk_idle_after_reset();

        // Basic log; first edge after reset sees 0 instead of 9 and must not log 9.
        pop_st.delete(); pop_dw.delete();
        repeat (3) cyc(0, 1'b1, 1'b0);
        chk("prime_no_push", 32'(bus.count), 32'd0);
        repeat (2) cyc(1, 1'b1, 1'b0);
        chk("basic_head_valid", 32'(bus.out_valid), 32'd0);
        cyc(2, 1'b1, 1'b0);
        chk("basic_push_visible", 32'(bus.count), 32'd1);
        repeat (3) cyc(2, 1'b1, 1'b0);
        chk("basic_pops", 32'(pop_st.size()), 32'd2);
        chk_pop("basic0", 0, 0, 3);
        chk_pop("basic1", 1, 1, 2);
        chk("basic_count", 32'(bus.count), 32'd0);

        // Backpressure and overflow: 10 changes into an 8-deep FIFO.
        cyc(0, 1'b0, 1'b1);
        pop_st.delete(); pop_dw.delete();
        cyc(0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) cyc(i % 2, 1'b0, 1'b0);
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        repeat (9) cyc(0, 1'b1, 1'b0);
        chk("drain_pops", 32'(pop_st.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_pop("drain", i, i % 2, 1);
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Full FIFO with push and pop on the same edge.
        cyc(0, 1'b0, 1'b1);
        pop_st.delete(); pop_dw.delete();
        cyc(0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) cyc(i % 2, 1'b0, 1'b0);
        repeat (2) cyc(0, 1'b0, 1'b0);
        chk("full_count", 32'(bus.count), 32'd8);
        cyc(5, 1'b1, 1'b0);
        chk("full_pp_count", 32'(bus.count), 32'd8);
        chk("full_pp_overflow", 32'(bus.overflow), 32'd0);
        repeat (9) cyc(5, 1'b1, 1'b0);
        chk("full_pp_pops", 32'(pop_st.size()), 32'd9);
        chk_pop("full_head", 0, 0, 1);
        chk_pop("full_second", 1, 1, 1);
        chk_pop("full_tail", 8, 0, 3);

        // Dwell counter boundary: 20 edges in state 5.
        cyc(0, 1'b1, 1'b1);
        pop_st.delete(); pop_dw.delete();
        repeat (20) cyc(5, 1'b1, 1'b0);
        cyc(6, 1'b1, 1'b0);
        cyc(6, 1'b1, 1'b0);
        chk("bound_pops", 32'(pop_st.size()), 32'd1);
`ifdef STATE_TRACKER_SAT_EN
        chk_pop("bound", 0, 5, 15);
`else
        chk_pop("bound", 0, 5, 4);
`endif

        // Reset mid-operation with three queued records.
        cyc(0, 1'b0, 1'b1);
        pop_st.delete(); pop_dw.delete();
        cyc(0, 1'b0, 1'b0);
        cyc(1, 1'b0, 1'b0);
        cyc(2, 1'b0, 1'b0);
        repeat (4) cyc(3, 1'b0, 1'b0);
        chk("mid_count", 32'(bus.count), 32'd3);
        cyc(3, 1'b0, 1'b1);
        chk_idle_after_reset();
        repeat (2) cyc(3, 1'b1, 1'b0);
        chk("mid_reprime", 32'(bus.count), 32'd0);
        cyc(7, 1'b1, 1'b0);
        cyc(7, 1'b1, 1'b0);
        chk("mid_pops", 32'(pop_st.size()), 32'd1);
        chk_pop("mid", 0, 3, 2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
